// File: rtl/timepulse_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// timepulse_sequencer : T01..Tn time-pulse ring, memory-cycle counter and
// halt/single-step control through the timer STOP line.   Rev 1.0
// ---------------------------------------------------------------------------
module timepulse_sequencer #(
  parameter int NSTAGES  = 12,
  parameter int CNT_W    = 16,
  parameter int STEP_LEN = 1
) (
  input  logic               CLOCK,
  input  logic               SIM_RST,
  input  logic               TPTICK,
  input  logic               HALT_REQ,
  input  logic               STEP_REQ,
  output logic [NSTAGES-1:0] TPULSE,
  output logic               EOC,
  output logic [CNT_W-1:0]   MCT_CNT,
  output logic               STOP,
  output logic               STEP_ACK,
  output logic [1:0]         STATE
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HALT_PEND = 2'd1,
    HALTED    = 2'd2,
    STEP      = 2'd3
  } state_t;

  localparam int                SC_W      = (STEP_LEN < 2) ? 1 : $clog2(STEP_LEN + 1);
  localparam logic [NSTAGES-1:0] T01      = NSTAGES'(1);
  localparam logic [SC_W-1:0]   STEP_LOAD = SC_W'(STEP_LEN);

  state_t          state;
  logic            step_prev;
  logic [SC_W-1:0] step_cnt;
  logic            step_edge;
  logic            advance;
  logic            wrap;

  assign step_edge = STEP_REQ & ~step_prev;
  assign advance   = TPTICK && (state != HALTED);
  // A wrap is the advance out of the last stage, i.e. a memory-cycle boundary.
  assign wrap      = advance && TPULSE[NSTAGES-1];
  assign STATE     = state;

  always_ff @(posedge CLOCK or negedge SIM_RST) begin
    if (!SIM_RST) begin
      state     <= RUN;
      TPULSE    <= T01;
      EOC       <= 1'b0;
      MCT_CNT   <= '0;
      STOP      <= 1'b0;
      STEP_ACK  <= 1'b0;
      step_prev <= 1'b0;
      step_cnt  <= '0;
    end else begin
      EOC       <= 1'b0;
      STEP_ACK  <= 1'b0;
      step_prev <= STEP_REQ;

      if (advance) begin
        TPULSE <= {TPULSE[NSTAGES-2:0], TPULSE[NSTAGES-1]};
      end
      if (wrap) begin
        EOC     <= 1'b1;
        MCT_CNT <= MCT_CNT + CNT_W'(1);
      end

      case (state)
        RUN: begin
          if (HALT_REQ) begin
            if (wrap) begin
              state <= HALTED;
              STOP  <= 1'b1;
            end else begin
              state <= HALT_PEND;
            end
          end
        end
        HALT_PEND: begin
          if (!HALT_REQ) begin
            state <= RUN;
          end else if (wrap) begin
            state <= HALTED;
            STOP  <= 1'b1;
          end
        end
        HALTED: begin
          // Dropping the halt wins over a coincident step request.
          if (!HALT_REQ) begin
            state <= RUN;
            STOP  <= 1'b0;
          end else if (step_edge) begin
            state    <= STEP;
            STOP     <= 1'b0;
            step_cnt <= STEP_LOAD;
          end
        end
        STEP: begin
          if (wrap) begin
            step_cnt <= step_cnt - SC_W'(1);
            if (step_cnt == SC_W'(1)) begin
              state    <= HALTED;
              STOP     <= 1'b1;
              STEP_ACK <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_timepulse_sequencer.sv
`default_nettype none
// Scoreboard bench for timepulse_sequencer: directed phases then random
// stimulus, checked every cycle against a stage-index reference model.
module tb_timepulse_sequencer;

  localparam int N  = 12;
  localparam int CW = 4;
  localparam int SL = 1;
  localparam int SW = 2 + 3 + CW + N;

  typedef logic [SW-1:0] snap_t;

  logic          clk = 1'b0;
  logic          rst_n, tick, halt, step;
  logic [N-1:0]  tpulse;
  logic          eoc, stop, ack;
  logic [CW-1:0] cnt;
  logic [1:0]    st;

  always #5 clk = ~clk;

  timepulse_sequencer #(.NSTAGES(N), .CNT_W(CW), .STEP_LEN(SL)) dut (
    .CLOCK(clk), .SIM_RST(rst_n), .TPTICK(tick), .HALT_REQ(halt),
    .STEP_REQ(step), .TPULSE(tpulse), .EOC(eoc), .MCT_CNT(cnt),
    .STOP(stop), .STEP_ACK(ack), .STATE(st)
  );

  snap_t q[$];
  int    pass_cnt  = 0;
  int    total_cnt = 0;

  // Reference model: stage index, completed-cycle tally, mode number, steps left.
  int m_pos, m_cycles, m_mode, m_left;
  bit m_prev, m_eoc, m_ack;

  function automatic void model_reset();
    m_pos = 0; m_cycles = 0; m_mode = 0; m_left = 0;
    m_prev = 0; m_eoc = 0; m_ack = 0;
  endfunction

  function automatic snap_t model_snap();
    logic [N-1:0] tp;
    logic         stp;
    tp = '0;
    tp[m_pos] = 1'b1;
    stp = (m_mode == 2);
    return {2'(m_mode), stp, m_ack, m_eoc, CW'(m_cycles), tp};
  endfunction

  function automatic void model_edge(bit t, bit h, bit s);
    bit sedge, adv, wrp;
    sedge  = s && !m_prev;
    m_prev = s;
    adv    = t && (m_mode != 2);
    wrp    = adv && (m_pos == N - 1);
    m_eoc  = 0;
    m_ack  = 0;
    if (adv) m_pos = (m_pos + 1) % N;
    if (wrp) begin
      m_eoc    = 1;
      m_cycles = (m_cycles + 1) % (1 << CW);
    end
    case (m_mode)
      0: if (h) m_mode = wrp ? 2 : 1;
      1: if (!h) m_mode = 0; else if (wrp) m_mode = 2;
      2: if (!h) m_mode = 0; else if (sedge) begin m_mode = 3; m_left = SL; end
      3: if (wrp) begin
           m_left = m_left - 1;
           if (m_left == 0) begin m_mode = 2; m_ack = 1; end
         end
      default: m_mode = 0;
    endcase
  endfunction

  function automatic snap_t dut_snap();
    return {st, stop, ack, eoc, cnt, tpulse};
  endfunction

  function automatic void check(string name, snap_t a, snap_t e);
    total_cnt++;
    if (a === e) pass_cnt++;
    else
      $display("FAIL %s: actual state=%0d stop=%b ack=%b eoc=%b cnt=%0d tpulse=%03h, required state=%0d stop=%b ack=%b eoc=%b cnt=%0d tpulse=%03h",
               name, a[SW-1:SW-2], a[SW-3], a[SW-4], a[SW-5], a[N+CW-1:N], a[N-1:0],
               e[SW-1:SW-2], e[SW-3], e[SW-4], e[SW-5], e[N+CW-1:N], e[N-1:0]);
  endfunction

  // Monitor: the DUT presents a full output word every cycle.
  snap_t exp_s;
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        exp_s = q.pop_front();
        check($sformatf("cycle@%0t", $time), dut_snap(), exp_s);
      end
    end
  end

  task automatic cyc(bit t, bit h, bit s);
    @(posedge clk);
    #1;
    rst_n = 1'b1; tick = t; halt = h; step = s;
    model_edge(t, h, s);
    q.push_back(model_snap());
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    q.delete();
    #1;
    model_reset();
    check("async_reset", dut_snap(), model_snap());
    q.push_back(model_snap());
  endtask

  task automatic halt_until_halted();
    for (int i = 0; i < 40 && m_mode != 2; i++) cyc(1, 1, 0);
  endtask

  initial begin
    rst_n = 1'b1; tick = 0; halt = 0; step = 0;
    #2 rst_n = 1'b0;
    model_reset();
    q.push_back(model_snap());

    // Ring walk with ticks spaced 4 cycles apart.
    for (int i = 0; i < N; i++) begin
      cyc(1, 0, 0);
      for (int j = 0; j < 3; j++) cyc(0, 0, 0);
    end

    // Halt raised at T05, held through the wrap, further ticks ignored.
    for (int i = 0; i < 20 && m_pos != 4; i++) cyc(1, 0, 0);
    halt_until_halted();
    for (int i = 0; i < 5; i++) cyc(1, 1, 0);

    // Single step with extra step edges while stepping.
    cyc(0, 1, 1);
    cyc(0, 1, 0);
    for (int i = 0; i < 40 && m_mode == 3; i++) cyc(1, 1, (i % 3) == 0);
    for (int i = 0; i < 4; i++) cyc(1, 1, 0);

    // Halt raised at T03 and dropped at T07 before any wrap.
    cyc(0, 0, 0);
    for (int i = 0; i < 20 && m_pos != 2; i++) cyc(1, 0, 0);
    for (int i = 0; i < 20 && m_pos != 6; i++) cyc(1, 1, 0);
    cyc(1, 0, 0);

    // Back-to-back ticks across a counter wrap.
    for (int i = 0; i < 17 * N; i++) cyc(1, 0, 0);

    // Reset while stepping at T09.
    halt_until_halted();
    cyc(0, 1, 1);
    for (int i = 0; i < 20 && m_pos != 8; i++) cyc(1, 1, 0);
    mid_reset();
    for (int i = 0; i < 4; i++) cyc(1, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit t, h, s;
      t = ($urandom_range(0, 2) != 0);
      h = halt;
      if ($urandom_range(0, 39) == 0) h = !halt;
      s = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 499) == 0) mid_reset();
      else cyc(t, h, s);
    end

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      total_cnt++;
      $display("FAIL drain: actual %0d entries left, required 0", q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
